sw_debounce_filter: RTL and testbench
=====================================

// Module: sw_debounce_filter
//
// PURPOSE
// - Conditions raw slide-switch/push-button levels before the 8-bit switch PIO input port.
// - Synchronises each asynchronous pad bit into clk with a 2-FF chain.
// - Per bit, rejects contact bounce shorter than DEBOUNCE_CYCLES clocks.
// - Drives clean levels on sw_stable, which connects straight to the PIO input port.
//
// PARAMETERS
// - WIDTH            8      number of switch bits
// - DEBOUNCE_CYCLES  50000  consecutive differing samples needed to accept a new level (>=1; 1 ms @ 50 MHz)
// - CNT_W            derived localparam = max(1, $clog2(DEBOUNCE_CYCLES)); per-bit counter width
//
// PORTS
// - clk         in   1      system clock
// - reset_n     in   1      reset; asynchronous, active-low
// - sw_raw      in   WIDTH  raw pad levels, asynchronous to clk
// - sw_stable   out  WIDTH  debounced levels; feed PIO in_port
// - sw_changed  out  WIDTH  1-cycle pulse per bit when its sw_stable bit toggles
// - busy        out  1      OR of all per-bit "counting" states
//
// BEHAVIOUR
// - Reset: sync FFs, sw_stable, sw_changed, busy and all counters = 0. Reset mid-count discards progress.
// - Sync: s1 <= sw_raw; s2 <= s1. Only s2 is compared; s1 is never used elsewhere.
// - Per-bit FSM:
//   - IDLE (s2 == stable, cnt = 0).
//   - COUNT (s2 != stable):
//     - Each edge with s2 != stable and cnt < D-1: cnt <= cnt+1.
//     - Edge with s2 != stable and cnt == D-1: stable <= s2, cnt <= 0, changed pulse, go to IDLE.
//     - Edge with s2 == stable (bounce): cnt <= 0, go to IDLE; no output change.
// - Latency: a clean raw step shows on sw_stable after exactly DEBOUNCE_CYCLES+2 rising edges.
// - DEBOUNCE_CYCLES = 1 degenerates to the 2-FF sync plus 1 register stage (3 edges).
// - Counter never wraps; the compare at D-1 bounds it.
// - Bits are independent. Simultaneous acceptance on several bits in one cycle produces simultaneous pulses.
// - busy is registered; it is 1 on cycles where any cnt != 0.
// - After reset with a switch held high: the bit rises after D+2 edges and pulses sw_changed. This is intended.
// - No combinational path from sw_raw to any output.
//
// CONFIGURATION
// - Macro SW_CHANGE_PULSE_EN:
//   - Defined: sw_changed is a registered 1-clk pulse, asserted the same cycle sw_stable updates.
//   - Undefined: sw_changed is tied to 0 and its flops are not built. The port list is unchanged.
//
// STRUCTURE
// - Package sw_debounce_pkg:
//   - typedef enum {DB_IDLE, DB_COUNT} db_state_t
//   - function db_cnt_w(int cycles) returning the counter width
//   - localparam DB_DEFAULT_CYCLES = 50000
// - Sub-module sw_debounce_bit (sync chain + FSM + counter for one bit).
//   - Instantiated WIDTH times via generate.
//   - Top level ORs the per-bit busy terms and registers busy.
//
// TESTING (bench uses DEBOUNCE_CYCLES=4, WIDTH=8, SW_CHANGE_PULSE_EN defined unless noted)
// 1. Reset hold, sw_raw=8'hFF.
//    -> All outputs 0 during reset.
//    -> sw_stable=8'hFF exactly 6 edges after release.
//    -> sw_changed=8'hFF for 1 cycle.
// 2. Clean step on bit0 (0->1) at edge N.
//    -> sw_stable[0]=1 after edge N+5, not before.
//    -> sw_changed[0] high for 1 cycle only.
// 3. Bit3 bounce 1,0,1,0 (1 clk each) then high.
//    -> No change during bounce.
//    -> sw_stable[3] rises 6 edges after the last rising transition.
// 4. Bits 1 and 6 step together.
//    -> Both update and pulse in the same cycle.
//    -> busy high 3 cycles, low afterwards.
// 5. Assert reset_n=0 mid-count on bit2 (cnt=2).
//    -> cnt and sw_stable clear immediately.
//    -> After release, full D+2 latency is required again.
// 6. SW_CHANGE_PULSE_EN undefined, repeat test 2.
//    -> sw_stable timing identical.
//    -> sw_changed stays 8'h00.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared types and sizing helpers for the switch debounce filter.
// Default debounce window is 1 ms at 50 MHz.
package sw_debounce_pkg;

   typedef enum logic {
      DB_IDLE,
      DB_COUNT
   } db_state_t;

   localparam int DB_DEFAULT_CYCLES = 50000;

   // The counter only ever holds 0..cycles-1, so clog2(cycles) bits suffice (min 1).
   function automatic int db_cnt_w(input int cycles);
      return (cycles <= 1) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, bounce-rejecting FSM and run-length counter.
// Latency DEBOUNCE_CYCLES+2 edges; no backpressure. Macro SW_CHANGE_PULSE_EN builds the change pulse flop.
module sw_debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DB_DEFAULT_CYCLES,
   parameter int CNT_W           = db_cnt_w(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_i,
   output logic stable_o,
   output logic changed_o,
   output logic busy_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   db_state_t        state_q, state_d;
   logic             accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         state_q  <= DB_IDLE;
      end else begin
         s1_q     <= raw_i;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      accept   = 1'b0;
      unique case (state_q)
         DB_IDLE: begin
            if (s2_q != stable_q) begin
               if (cnt_q == LAST) begin
                  accept = 1'b1;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = DB_COUNT;
               end
            end
         end
         DB_COUNT: begin
            if (s2_q == stable_q) begin
               cnt_d   = '0;
               state_d = DB_IDLE;
            end else if (cnt_q == LAST) begin
               accept = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = DB_IDLE;
         end
      endcase
      if (accept) begin
         stable_d = s2_q;
         cnt_d    = '0;
         state_d  = DB_IDLE;
      end
   end

   assign stable_o = stable_q;
   // Next-state view so the registered busy at the top lines up with the count.
   assign busy_o   = (cnt_d != '0);

`ifdef SW_CHANGE_PULSE_EN
   logic changed_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) changed_q <= 1'b0;
      else          changed_q <= accept;
   end

   assign changed_o = changed_q;
`else
   assign changed_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce_filter.sv
// Debounces WIDTH raw switch pads into clean PIO levels; optional change pulses via SW_CHANGE_PULSE_EN.
// Latency DEBOUNCE_CYCLES+2 edges per bit; no backpressure, every output is a flop.
module sw_debounce_filter
   import sw_debounce_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = DB_DEFAULT_CYCLES
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_changed,
   output logic             busy
);

   localparam int CNT_W = db_cnt_w(DEBOUNCE_CYCLES);

   logic [WIDTH-1:0] busy_term;
   logic             busy_q;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      sw_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_bit (
         .clk       (clk),
         .reset_n   (reset_n),
         .raw_i     (sw_raw[g]),
         .stable_o  (sw_stable[g]),
         .changed_o (sw_changed[g]),
         .busy_o    (busy_term[g])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) busy_q <= 1'b0;
      else          busy_q <= |busy_term;
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_sw_debounce_filter.sv
// Directed bench for sw_debounce_filter with DEBOUNCE_CYCLES=4, WIDTH=8.
// Expected change pulses follow whether SW_CHANGE_PULSE_EN is defined for this build.
module tb_sw_debounce_filter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] sw_raw;
   logic [7:0] sw_stable;
   logic [7:0] sw_changed;
   logic       busy;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

`ifdef SW_CHANGE_PULSE_EN
   localparam bit PULSE_ON = 1'b1;
`else
   localparam bit PULSE_ON = 1'b0;
`endif

   sw_debounce_filter #(
      .WIDTH           (8),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sw_raw     (sw_raw),
      .sw_stable  (sw_stable),
      .sw_changed (sw_changed),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] chg(input logic [7:0] v);
      return PULSE_ON ? v : 8'h00;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with all switches high
      reset_n = 1'b0;
      sw_raw  = 8'hFF;
      tick(3);
      chk("rst_stable",  sw_stable,  8'h00);
      chk("rst_changed", sw_changed, 8'h00);
      chk("rst_busy",    {7'd0, busy}, 8'h00);
      reset_n = 1'b1;
      tick(5);
      chk("rel_stable_e5", sw_stable, 8'h00);
      chk("rel_busy_e5",   {7'd0, busy}, 8'h01);
      tick(1);
      chk("rel_stable_e6",  sw_stable,  8'hFF);
      chk("rel_changed_e6", sw_changed, chg(8'hFF));
      tick(1);
      chk("rel_changed_e7", sw_changed, 8'h00);
      chk("rel_busy_e7",    {7'd0, busy}, 8'h00);

      // Release everything back to 0
      sw_raw = 8'h00;
      tick(8);
      chk("clear_stable", sw_stable, 8'h00);

      // Clean rising step on bit0
      sw_raw = 8'h01;
      tick(5);
      chk("step0_e5", sw_stable, 8'h00);
      tick(1);
      chk("step0_e6",     sw_stable,  8'h01);
      chk("step0_chg_e6", sw_changed, chg(8'h01));
      tick(1);
      chk("step0_chg_e7", sw_changed, 8'h00);

      // Bit3 bounces 1,0,1,0 then settles high
      sw_raw = 8'h09; tick(1); chk("bnc_a", sw_stable, 8'h01);
      sw_raw = 8'h01; tick(1); chk("bnc_b", sw_stable, 8'h01);
      sw_raw = 8'h09; tick(1); chk("bnc_c", sw_stable, 8'h01);
      sw_raw = 8'h01; tick(1); chk("bnc_d", sw_stable, 8'h01);
      sw_raw = 8'h09;
      tick(5);
      chk("bnc_e5",     sw_stable,  8'h01);
      chk("bnc_chg_e5", sw_changed, 8'h00);
      tick(1);
      chk("bnc_e6",     sw_stable,  8'h09);
      chk("bnc_chg_e6", sw_changed, chg(8'h08));
      tick(1);
      chk("bnc_chg_e7", sw_changed, 8'h00);

      // Bits 1 and 6 step together
      sw_raw = 8'h4B;
      tick(2);
      chk("pair_busy_e2", {7'd0, busy}, 8'h00);
      tick(1);
      chk("pair_busy_e3", {7'd0, busy}, 8'h01);
      tick(1);
      chk("pair_busy_e4", {7'd0, busy}, 8'h01);
      tick(1);
      chk("pair_busy_e5",   {7'd0, busy}, 8'h01);
      chk("pair_stable_e5", sw_stable, 8'h09);
      tick(1);
      chk("pair_busy_e6",   {7'd0, busy}, 8'h00);
      chk("pair_stable_e6", sw_stable,  8'h4B);
      chk("pair_chg_e6",    sw_changed, chg(8'h42));
      tick(1);
      chk("pair_busy_e7", {7'd0, busy}, 8'h00);
      chk("pair_chg_e7",  sw_changed,   8'h00);

      // Reset while bit2 is mid-count
      sw_raw = 8'h4F;
      tick(4);
      chk("mid_busy", {7'd0, busy}, 8'h01);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_stable",  sw_stable,  8'h00);
      chk("mid_rst_busy",    {7'd0, busy}, 8'h00);
      chk("mid_rst_changed", sw_changed, 8'h00);
      tick(2);
      reset_n = 1'b1;
      tick(5);
      chk("mid_rel_e5", sw_stable, 8'h00);
      tick(1);
      chk("mid_rel_e6",     sw_stable,  8'h4F);
      chk("mid_rel_chg_e6", sw_changed, chg(8'h4F));
      tick(1);

      // Falling step on bit0
      sw_raw = 8'h4E;
      tick(5);
      chk("fall0_e5", sw_stable, 8'h4F);
      tick(1);
      chk("fall0_e6",     sw_stable,  8'h4E);
      chk("fall0_chg_e6", sw_changed, chg(8'h01));
      tick(1);
      chk("fall0_chg_e7", sw_changed, 8'h00);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
